// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults, derived totals, sync-window bounds and scan state type.
// Defaults describe 640x480@60 with active-low syncs.
package vga_timing_pkg;
   localparam int H_ACTIVE_D = 640;
   localparam int H_FRONT_D  = 16;
   localparam int H_SYNC_D   = 96;
   localparam int H_BACK_D   = 48;
   localparam int V_ACTIVE_D = 480;
   localparam int V_FRONT_D  = 10;
   localparam int V_SYNC_D   = 2;
   localparam int V_BACK_D   = 33;
   localparam int CW_D       = 10;

   localparam int H_TOTAL_D = H_ACTIVE_D + H_FRONT_D + H_SYNC_D + H_BACK_D;
   localparam int V_TOTAL_D = V_ACTIVE_D + V_FRONT_D + V_SYNC_D + V_BACK_D;

   // Sync windows are half-open: [START, END).
   localparam int H_SYNC_START_D = H_ACTIVE_D + H_FRONT_D;
   localparam int H_SYNC_END_D   = H_SYNC_START_D + H_SYNC_D;
   localparam int V_SYNC_START_D = V_ACTIVE_D + V_FRONT_D;
   localparam int V_SYNC_END_D   = V_SYNC_START_D + V_SYNC_D;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;
endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with sync-window and active-area flags
// registered from the next position, so the flags always line up with pos.
module vga_axis_counter #(
   parameter int CW         = 10,
   parameter int TOTAL      = 800,
   parameter int SYNC_START = 656,
   parameter int SYNC_END   = 752,
   parameter int ACTIVE     = 640
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          advance,
   input  logic          clear,
   output logic [CW-1:0] pos,
   output logic          wrap,
   output logic          sync_win,
   output logic          active_win
);
   localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);
   localparam logic [CW-1:0] SS   = CW'(SYNC_START);
   localparam logic [CW-1:0] SE   = CW'(SYNC_END);
   localparam logic [CW-1:0] ACT  = CW'(ACTIVE);

   logic [CW-1:0] pos_nxt;

   always_comb begin
      wrap    = advance && (pos == LAST);
      pos_nxt = pos;
      if (clear || wrap)
         pos_nxt = '0;
      else if (advance)
         pos_nxt = pos + CW'(1);
   end

   // clear also drops the flags, so they read as "outside" while the scan is idle
   always_ff @(posedge clk) begin
      if (reset) begin
         pos        <= '0;
         sync_win   <= 1'b0;
         active_win <= 1'b0;
      end else begin
         pos <= pos_nxt;
         if (clear) begin
            sync_win   <= 1'b0;
            active_win <= 1'b0;
         end else begin
            sync_win   <= (pos_nxt >= SS) && (pos_nxt < SE);
            active_win <= (pos_nxt < ACT);
         end
      end
   end
endmodule

// File: rtl/vga_timing_ctrl.sv
// Raster timing sequencer: advances (x,y) on pixel ticks, produces syncs, active flag and strobes.
// Scanning starts on a tick with run=1 and only stops at the end of a complete frame.
module vga_timing_ctrl
   import vga_timing_pkg::*;
#(
   parameter int   H_ACTIVE = H_ACTIVE_D,
   parameter int   H_FRONT  = H_FRONT_D,
   parameter int   H_SYNC   = H_SYNC_D,
   parameter int   H_BACK   = H_BACK_D,
   parameter int   V_ACTIVE = V_ACTIVE_D,
   parameter int   V_FRONT  = V_FRONT_D,
   parameter int   V_SYNC   = V_SYNC_D,
   parameter int   V_BACK   = V_BACK_D,
   parameter logic SYNC_POL = 1'b0,
   parameter int   CW       = CW_D
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          pix_en,
   input  logic          run,
   output logic          hsync,
   output logic          vsync,
   output logic          active,
   output logic [CW-1:0] x,
   output logic [CW-1:0] y,
   output logic          line_start,
   output logic          frame_start,
   output logic          busy
);
   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   state_t state, state_nxt;
   logic   h_adv, h_wrap, v_wrap, start, stop, clear;
   logic   h_sync_win, v_sync_win, h_act, v_act;
   logic   ls_nxt, fs_nxt;

   assign h_adv = (state == SCAN) && pix_en;
   assign start = (state == IDLE) && pix_en && run;
   // v_wrap only fires on the h_wrap tick, so it marks the last tick of the frame
   assign stop  = v_wrap && !run;
   assign clear = ((state == IDLE) && !start) || stop;

   vga_axis_counter #(
      .CW(CW), .TOTAL(H_TOTAL), .SYNC_START(H_ACTIVE + H_FRONT),
      .SYNC_END(H_ACTIVE + H_FRONT + H_SYNC), .ACTIVE(H_ACTIVE)
   ) u_h (
      .clk(clk), .reset(reset), .advance(h_adv), .clear(clear),
      .pos(x), .wrap(h_wrap), .sync_win(h_sync_win), .active_win(h_act)
   );

   vga_axis_counter #(
      .CW(CW), .TOTAL(V_TOTAL), .SYNC_START(V_ACTIVE + V_FRONT),
      .SYNC_END(V_ACTIVE + V_FRONT + V_SYNC), .ACTIVE(V_ACTIVE)
   ) u_v (
      .clk(clk), .reset(reset), .advance(h_wrap), .clear(clear),
      .pos(y), .wrap(v_wrap), .sync_win(v_sync_win), .active_win(v_act)
   );

   always_comb begin
      state_nxt = state;
      ls_nxt    = 1'b0;
      fs_nxt    = 1'b0;
      case (state)
         IDLE: if (start) begin
            state_nxt = SCAN;
            ls_nxt    = 1'b1;
            fs_nxt    = 1'b1;
         end
         SCAN: if (stop) begin
            state_nxt = IDLE;
         end else begin
            ls_nxt = h_wrap;
            fs_nxt = v_wrap;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         state       <= state_nxt;
         line_start  <= ls_nxt;
         frame_start <= fs_nxt;
      end
   end

   // Window flags are already zero outside SCAN, so these need no extra state gating.
   assign busy   = (state == SCAN);
   assign hsync  = h_sync_win ? SYNC_POL : ~SYNC_POL;
   assign vsync  = v_sync_win ? SYNC_POL : ~SYNC_POL;
   assign active = h_act & v_act;
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench: a default-timing instance and a shrunken-timing instance (full frames in few cycles),
// both compared every cycle against a linear-index raster model.
module tb_vga_timing_ctrl;
   logic clk = 1'b0;
   logic reset, pix_en, run;

   logic       hs0, vs0, act0, ls0, fs0, b0;
   logic [9:0] x0, y0;
   logic       hs1, vs1, act1, ls1, fs1, b1;
   logic [5:0] x1, y1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   vga_timing_ctrl dut0 (
      .clk(clk), .reset(reset), .pix_en(pix_en), .run(run),
      .hsync(hs0), .vsync(vs0), .active(act0), .x(x0), .y(y0),
      .line_start(ls0), .frame_start(fs0), .busy(b0)
   );

   vga_timing_ctrl #(
      .H_ACTIVE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
      .V_ACTIVE(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
      .SYNC_POL(1'b1), .CW(6)
   ) dut1 (
      .clk(clk), .reset(reset), .pix_en(pix_en), .run(run),
      .hsync(hs1), .vsync(vs1), .active(act1), .x(x1), .y(y1),
      .line_start(ls1), .frame_start(fs1), .busy(b1)
   );

   // Timing per instance: [0] = defaults, [1] = shrunken
   int p_ha[2] = '{640, 16};
   int p_hf[2] = '{16, 4};
   int p_hs[2] = '{96, 6};
   int p_hb[2] = '{48, 4};
   int p_va[2] = '{480, 10};
   int p_vf[2] = '{10, 2};
   int p_vs[2] = '{2, 2};
   int p_vb[2] = '{33, 3};
   bit p_pol[2] = '{1'b0, 1'b1};

   // Model: position is a single linear pixel index p within the frame
   bit m_scan[2];
   int m_p[2];
   bit m_ls[2];
   bit m_fs[2];
   bit chk_en = 1'b0;
   int tick_cnt = 0;
   bit ivl_valid = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int htot(input int i);
      return p_ha[i] + p_hf[i] + p_hs[i] + p_hb[i];
   endfunction

   function automatic int vtot(input int i);
      return p_va[i] + p_vf[i] + p_vs[i] + p_vb[i];
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         int ht, n;
         ht = htot(i);
         n  = ht * vtot(i);
         m_ls[i] = 1'b0;
         m_fs[i] = 1'b0;
         if (reset) begin
            m_scan[i] = 1'b0;
            m_p[i]    = 0;
         end else if (pix_en) begin
            if (!m_scan[i]) begin
               if (run) begin
                  m_scan[i] = 1'b1;
                  m_p[i]    = 0;
                  m_ls[i]   = 1'b1;
                  m_fs[i]   = 1'b1;
               end
            end else if (m_p[i] == n - 1) begin
               m_p[i] = 0;
               if (run) begin
                  m_ls[i] = 1'b1;
                  m_fs[i] = 1'b1;
               end else begin
                  m_scan[i] = 1'b0;
               end
            end else begin
               m_p[i]  = m_p[i] + 1;
               m_ls[i] = (m_p[i] % ht == 0);
            end
         end
      end
      if (!reset && pix_en) tick_cnt++;
      if (reset) chk_en = 1'b1;
   end

   task automatic check_dut(input int i, input int x, input int y, input logic hs, input logic vs,
                            input logic act, input logic ls, input logic fs, input logic bsy);
      int ex, ey, hstart, vstart;
      bit hon, von;
      ex     = m_p[i] % htot(i);
      ey     = m_p[i] / htot(i);
      hstart = p_ha[i] + p_hf[i];
      vstart = p_va[i] + p_vf[i];
      hon    = m_scan[i] && ex >= hstart && ex < hstart + p_hs[i];
      von    = m_scan[i] && ey >= vstart && ey < vstart + p_vs[i];
      check($sformatf("d%0d.x", i), x, ex);
      check($sformatf("d%0d.y", i), y, ey);
      check($sformatf("d%0d.hsync", i), {31'd0, hs}, {31'd0, hon ? p_pol[i] : ~p_pol[i]});
      check($sformatf("d%0d.vsync", i), {31'd0, vs}, {31'd0, von ? p_pol[i] : ~p_pol[i]});
      check($sformatf("d%0d.active", i), {31'd0, act},
            {31'd0, m_scan[i] && ex < p_ha[i] && ey < p_va[i]});
      check($sformatf("d%0d.line_start", i), {31'd0, ls}, {31'd0, m_ls[i]});
      check($sformatf("d%0d.frame_start", i), {31'd0, fs}, {31'd0, m_fs[i]});
      check($sformatf("d%0d.busy", i), {31'd0, bsy}, {31'd0, m_scan[i]});
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check_dut(0, x0, y0, hs0, vs0, act0, ls0, fs0, b0);
         check_dut(1, x1, y1, hs1, vs1, act1, ls1, fs1, b1);
         // ticks between consecutive frame_start pulses of an uninterrupted scan
         if (!b1) begin
            ivl_valid = 1'b0;
         end else if (fs1) begin
            if (ivl_valid) check("d1.frame_len", tick_cnt, htot(1) * vtot(1));
            ivl_valid = 1'b1;
            tick_cnt  = 0;
         end
      end
   end

   initial begin
      reset  = 1'b1;
      pix_en = 1'b0;
      run    = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      // idle with ticks present but run low
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         pix_en = (c % 4 == 3);
      end
      // continuous ticks: full lines on default timing, several frames on small timing
      run = 1'b1;
      for (int c = 0; c < 2500; c++) begin
         @(negedge clk);
         pix_en = 1'b1;
      end
      // irregular tick spacing
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         pix_en = 1'($urandom_range(0, 1));
      end
      // drop run mid-frame, let the small instance complete and park, then restart
      @(negedge clk);
      run = 1'b0;
      for (int c = 0; c < 1200; c++) begin
         @(negedge clk);
         pix_en = 1'b1;
      end
      run = 1'b1;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         pix_en = 1'b1;
      end
      // mixed random traffic with occasional run toggles and resets
      for (int c = 0; c < 12000; c++) begin
         @(negedge clk);
         pix_en = ($urandom % 3) != 0;
         if ($urandom % 400 == 0) run = ~run;
         reset = ($urandom % 1500 == 0);
      end
      // explicit reset in the middle of a scan
      @(negedge clk);
      reset  = 1'b0;
      run    = 1'b1;
      pix_en = 1'b1;
      repeat (150) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      run   = 1'b0;
      repeat (50) @(negedge clk);
      @(posedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
